// File: rtl/csa_final_adder.sv
// rtl/csa_final_adder.sv - two-stage pipelined carry-propagate adder resolving a carry-save pair
// Optional feature macro: FINAL_ADD_STICKY_EN (registers sticky = |P[STICKY_W-1:0]; otherwise sticky is tied low)
module csa_final_adder #(
  parameter int LENGTH   = 32,
  parameter int STICKY_W = LENGTH - 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*LENGTH+1:0] C,
  input  logic [2*LENGTH+1:0] D,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*LENGTH+1:0] P,
  output logic                sticky
);

  localparam int W    = 2 * LENGTH + 2;
  localparam int H    = LENGTH + 1;
  localparam int HI_W = W - H;

  // Stage 1 state: resolved low half plus the untouched high operand halves
  logic            r_s1_valid;
  logic [H-1:0]    r_s1_lo;
  logic            r_s1_cy;
  logic [HI_W-1:0] r_s1_dhi;
  logic [HI_W-1:0] r_s1_chi;

  // Stage 2 state: the registered result
  logic            r_s2_valid;
  logic [W-1:0]    r_p;

  logic            w_s1_load;
  logic            w_s2_load;
  logic [H:0]      w_lo_sum;
  logic [HI_W-1:0] w_hi_sum;
  logic [W-1:0]    w_p_next;

  // The top carry bit would land at weight 2^W and is always shifted out.
  logic w_unused_c_top;
  assign w_unused_c_top = C[W-1];

  // Handshake: a full pipe only accepts when the result is leaving the same cycle
  assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
  assign w_s1_load = in_valid && in_ready;
  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);

  // Low half add: D plus C shifted up one place, carry kept in the extra bit
  assign w_lo_sum = {1'b0, D[H-1:0]} + {1'b0, C[H-2:0], 1'b0};

  // High half add, folding in the stage 1 carry; the carry out of bit W-1 is dropped
  assign w_hi_sum = r_s1_dhi + r_s1_chi + {{(HI_W-1){1'b0}}, r_s1_cy};
  assign w_p_next = {w_hi_sum, r_s1_lo};

  // Valid bits: the only state that must be reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  // Stage 1 data capture on input transfer; stale contents are harmless when invalid
  always_ff @(posedge sys_clk) begin
    if (w_s1_load) begin
      r_s1_lo  <= w_lo_sum[H-1:0];
      r_s1_cy  <= w_lo_sum[H];
      r_s1_dhi <= D[W-1:H];
      r_s1_chi <= C[W-2:H-1];
    end
  end

  // Result register; cleared by reset so P reads zero while the pipe is empty
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_p <= '0;
    end else if (w_s2_load) begin
      r_p <= w_p_next;
    end
  end

  assign out_valid = r_s2_valid;
  assign P         = r_p;

`ifdef FINAL_ADD_STICKY_EN
  logic w_sticky_next;
  logic r_sticky;

  if (STICKY_W <= H) begin : g_sticky_lo
    assign w_sticky_next = |r_s1_lo[STICKY_W-1:0];
  end else begin : g_sticky_full
    assign w_sticky_next = |w_p_next[STICKY_W-1:0];
  end

  // Sticky travels with P: same load enable, same reset value
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_s2_load) begin
      r_sticky <= w_sticky_next;
    end
  end

  assign sticky = r_sticky;
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_csa_final_adder.sv
// tb/tb_csa_final_adder.sv - directed self-checking bench for csa_final_adder
module tb_csa_final_adder;

  localparam int LENGTH   = 32;
  localparam int W        = 2 * LENGTH + 2;
  localparam int STICKY_W = LENGTH - 1;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] C;
  logic [W-1:0] D;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] P;
  logic         sticky;

  int tests  = 0;
  int failed = 0;

  csa_final_adder #(.LENGTH(LENGTH), .STICKY_W(STICKY_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .C         (C),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .sticky    (sticky)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic exp_sticky(input logic [W-1:0] p);
`ifdef FINAL_ADD_STICKY_EN
    return |p[STICKY_W-1:0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    C = '0;
    D = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++;
    if (P !== '0) begin failed++; $display("FAIL reset_p: got %0h expected 0", P); end
    tests++;
    if (sticky !== 1'b0) begin failed++; $display("FAIL reset_sticky: got %b expected 0", sticky); end
  endtask

  task automatic run_single(input string name, input logic [W-1:0] c, input logic [W-1:0] d,
                            input logic [W-1:0] exp_p);
    @(negedge sys_clk);
    C = c;
    D = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tests++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL %s_latency_early: got %b expected 0", name, out_valid); end
    @(posedge sys_clk);
    #1;
    tests++;
    if (out_valid !== 1'b1) begin failed++; $display("FAIL %s_out_valid: got %b expected 1", name, out_valid); end
    tests++;
    if (P !== exp_p) begin failed++; $display("FAIL %s_p: got %0h expected %0h", name, P, exp_p); end
    tests++;
    if (sticky !== exp_sticky(exp_p)) begin
      failed++; $display("FAIL %s_sticky: got %b expected %b", name, sticky, exp_sticky(exp_p));
    end
    @(posedge sys_clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL %s_drain: got %b expected 0", name, out_valid); end
  endtask

  task automatic test_basic();
    run_single("basic_5", 66'h0, 66'h5, 66'h5);
    run_single("basic_3", 66'h1, 66'h1, 66'h3);
    run_single("basic_0", 66'h0, 66'h0, 66'h0);
  endtask

  task automatic test_carry();
    run_single("half_carry", 66'h1, 66'h1_FFFF_FFFF, 66'h2_0000_0001);
  endtask

  task automatic test_wrap();
    run_single("wrap_all_ones", 66'h1, 66'h3_FFFF_FFFF_FFFF_FFFF, 66'h1);
    run_single("wrap_c_top", 66'h2_0000_0000_0000_0000, 66'h0, 66'h0);
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] pc [3];
    logic [W-1:0] pd [3];
    logic [W-1:0] pe [3];
    pc[0] = 66'h0;           pd[0] = 66'd100;          pe[0] = 66'd100;
    pc[1] = 66'h3;           pd[1] = 66'd7;            pe[1] = 66'd13;
    pc[2] = 66'h80_0000_0000; pd[2] = 66'h100_0000_0000; pe[2] = 66'h200_0000_0000;

    @(negedge sys_clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    C = pc[0];
    D = pd[0];
    tests++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL bp_ready0: got %b expected 1", in_ready); end
    @(posedge sys_clk);
    #1;
    C = pc[1];
    D = pd[1];
    tests++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL bp_ready1: got %b expected 1", in_ready); end
    @(posedge sys_clk);
    #1;
    C = pc[2];
    D = pd[2];
    tests++;
    if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_full: got %b expected 0", in_ready); end
    tests++;
    if (out_valid !== 1'b1 || P !== pe[0]) begin
      failed++; $display("FAIL bp_first: got v=%b p=%0h expected v=1 p=%0h", out_valid, P, pe[0]);
    end
    @(posedge sys_clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_still_full: got %b expected 0", in_ready); end
    tests++;
    if (out_valid !== 1'b1 || P !== pe[0]) begin
      failed++; $display("FAIL bp_hold: got v=%b p=%0h expected v=1 p=%0h", out_valid, P, pe[0]);
    end
    @(negedge sys_clk);
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || P !== pe[1]) begin
      failed++; $display("FAIL bp_second: got v=%b p=%0h expected v=1 p=%0h", out_valid, P, pe[1]);
    end
    @(posedge sys_clk);
    #1;
    tests++;
    if (out_valid !== 1'b1 || P !== pe[2]) begin
      failed++; $display("FAIL bp_third: got v=%b p=%0h expected v=1 p=%0h", out_valid, P, pe[2]);
    end
    @(posedge sys_clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_p [4];
    for (int i = 0; i < 4; i++) begin
      exp_p[i] = W'(i * 1000 + 1) + W'(2 * (i + 5));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (i < 4) begin
        in_valid = 1'b1;
        D = W'(i * 1000 + 1);
        C = W'(i + 5);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge sys_clk);
      #1;
      if (i >= 1 && i <= 4) begin
        tests++;
        if (out_valid !== 1'b1 || P !== exp_p[i-1]) begin
          failed++;
          $display("FAIL b2b_result%0d: got v=%b p=%0h expected v=1 p=%0h", i - 1, out_valid, P, exp_p[i-1]);
        end
      end else if (i == 5) begin
        tests++;
        if (out_valid !== 1'b0) begin failed++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge sys_clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    C = 66'h0;
    D = 66'd42;
    @(posedge sys_clk);
    #1;
    D = 66'd43;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failed++; $display("FAIL rst_fill: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || P !== '0) begin
      failed++; $display("FAIL rst_async: got v=%b p=%0h expected v=0 p=0", out_valid, P);
    end
    tests++;
    if (in_ready !== 1'b1) begin failed++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk);
      #1;
      tests++;
      if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_no_stale%0d: got %b expected 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_wrap();
    test_back_pressure();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
